// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// sweep geometry and the default expected truth vector.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  localparam int TT_POINTS = 8;
  localparam int TT_IDX_W  = 3;
  localparam int TT_CNT_W  = 4;

  localparam logic [TT_POINTS-1:0] TT_EXPECTED_DEFAULT = 8'hA2;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper (slave) and whoever starts it
// and supplies the function block's y output (master).
interface truth_table_sweeper_if;
  import tt_pkg::*;

  logic                start;
  logic                y_in;
  logic [TT_IDX_W-1:0] bcd_out;
  logic                busy;
  logic                done;
  logic [TT_POINTS-1:0] truth;
  logic                match;

  modport slave (
    input  start, y_in,
    output bcd_out, busy, done, truth, match
  );

  modport master (
    output start, y_in,
    input  bcd_out, busy, done, truth, match
  );

endinterface

// File: rtl/tt_settle_counter.sv
// Loadable settle-time down-counter; load wins over dec, dec stops at zero.
module tt_settle_counter
  import tt_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [TT_CNT_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [TT_CNT_W-1:0] cnt_q;
  logic [TT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks {B,C,D} through 000..111, samples y after a settle time and flags a
// match against EXPECTED. Define TT_CONTINUOUS_EN to re-sweep back to back.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int                   SETTLE_CYCLES = 1,
  parameter logic [TT_POINTS-1:0] EXPECTED      = TT_EXPECTED_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam logic [TT_CNT_W-1:0] RELOAD   = TT_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_POINTS - 1);

  tt_state_t            state_q;
  logic [TT_IDX_W-1:0]  idx_q;
  logic [TT_POINTS-1:0] truth_q;
  logic                 match_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;

  // The visible done cycle trails the DONE state by one edge (so match is
  // already valid); start is still ignored during that cycle.
  assign accept = (state_q == IDLE) && bus.start && !done_q;

  always_comb begin
    cnt_load = accept || ((state_q == SAMPLE) && (idx_q != LAST_IDX));
`ifdef TT_CONTINUOUS_EN
    cnt_load = cnt_load || (state_q == DONE);
`endif
    cnt_dec  = (state_q == SETTLE) && !cnt_zero;
  end

  tt_settle_counter u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (RELOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      truth_q <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (accept) begin
            truth_q <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          done_q <= 1'b0;
          if (cnt_zero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          truth_q[idx_q] <= bus.y_in;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          match_q <= (truth_q == EXPECTED);
`ifdef TT_CONTINUOUS_EN
          truth_q <= '0;
          idx_q   <= '0;
          state_q <= SETTLE;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // bcd_out always equals the point index, including holding 111 after a sweep
  assign bus.bcd_out = idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.truth   = truth_q;
  assign bus.match   = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table-driven sweeps against the reference function model,
// plus hand sequences for start-while-busy, reset and continuous mode.
module tb_truth_table_sweeper;
  import tt_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  truth_table_sweeper_if if_a ();
  truth_table_sweeper_if if_b ();

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hA2)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hA2)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference function: y = (~C & D) | (B & C & D)
  function automatic logic model_y(input logic [2:0] bcd);
    return (~bcd[1] & bcd[0]) | (bcd[2] & bcd[1] & bcd[0]);
  endfunction

  logic fault;
  assign if_a.y_in = model_y(if_a.bcd_out) & ~(fault && (if_a.bcd_out == 3'b101));

  // dut_b sees a function block whose y lags its inputs by 3 cycles
  logic [2:0] d1, d2, d3;
  always @(posedge clk) begin
    d1 <= if_b.bcd_out;
    d2 <= d1;
    d3 <= d2;
  end
  assign if_b.y_in = model_y(d3);

  logic       sel_b;
  logic [2:0] m_bcd;
  logic       m_busy, m_done, m_match;
  logic [7:0] m_truth;
  always_comb begin
    if (sel_b) begin
      m_bcd = if_b.bcd_out; m_busy = if_b.busy; m_done = if_b.done;
      m_truth = if_b.truth; m_match = if_b.match;
    end else begin
      m_bcd = if_a.bcd_out; m_busy = if_a.busy; m_done = if_a.done;
      m_truth = if_a.truth; m_match = if_a.match;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_start(input bit use_b, input logic v);
    if (use_b) if_b.start = v;
    else       if_a.start = v;
  endtask

  task automatic pulse_start(input bit use_b);
    @(negedge clk);
    drive_start(use_b, 1'b1);
    @(posedge clk);
    #1;
    drive_start(use_b, 1'b0);
  endtask

  typedef struct {
    string      name;
    bit         use_b;
    bit         flt;
    int         settle;
    logic [7:0] exp_truth;
    bit         exp_match;
    int         exp_edge;
  } vec_t;

  task automatic sweep(input vec_t v);
    int         done_cnt;
    int         done_at;
    bit         seq_ok;
    bit         busy_ok;
    int         n;
    logic [2:0] exp_bcd;
    done_cnt = 0; done_at = -1; seq_ok = 1'b1; busy_ok = 1'b1;
    n = 8 * (v.settle + 1);
    sel_b = v.use_b;
    fault = v.flt;
    pulse_start(v.use_b);
    if (m_bcd !== 3'd0 || m_busy !== 1'b1) seq_ok = 1'b0;
    for (int e = 1; e <= v.exp_edge + 3; e++) begin
      @(posedge clk);
      #1;
      exp_bcd = (e < n) ? 3'(e / (v.settle + 1)) : 3'd7;
      if (m_bcd !== exp_bcd) seq_ok = 1'b0;
      if (e <= v.exp_edge && m_busy !== 1'b1) busy_ok = 1'b0;
      if (e > v.exp_edge && m_busy !== 1'b0) busy_ok = 1'b0;
      if (m_done === 1'b1) begin
        done_cnt++;
        done_at = e;
        chk({v.name, " truth"}, 32'(m_truth), 32'(v.exp_truth));
        chk({v.name, " match"}, 32'(m_match), 32'(v.exp_match));
      end
    end
    chk({v.name, " done count"}, 32'(done_cnt), 32'd1);
    chk({v.name, " done edge"}, 32'(done_at), 32'(v.exp_edge));
    chk({v.name, " bcd sequence"}, 32'(seq_ok), 32'd1);
    chk({v.name, " busy window"}, 32'(busy_ok), 32'd1);
    $display("sweep %s: truth=%02h match=%0b done_at=%0d", v.name, m_truth, m_match, done_at);
    fault = 1'b0;
  endtask

  vec_t vecs[4];
  int   done_cnt;
  int   done_edges[3];
  logic [7:0] prev_truth;
  bit   busy_ok;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; fault = 1'b0; sel_b = 1'b0;
    if_a.start = 1'b0; if_b.start = 1'b0;
    vecs[0] = '{"nominal",   1'b0, 1'b0, 1, 8'hA2, 1'b1, 17};
    vecs[1] = '{"fault101",  1'b0, 1'b1, 1, 8'h82, 1'b0, 17};
    vecs[2] = '{"settle4",   1'b1, 1'b0, 4, 8'hA2, 1'b1, 41};
    vecs[3] = '{"nominal2",  1'b0, 1'b0, 1, 8'hA2, 1'b1, 17};
    repeat (3) @(posedge clk);
    #1;
    chk("reset bcd",   32'(if_a.bcd_out), 32'd0);
    chk("reset busy",  32'(if_a.busy),    32'd0);
    chk("reset done",  32'(if_a.done),    32'd0);
    chk("reset truth", 32'(if_a.truth),   32'd0);
    chk("reset match", 32'(if_a.match),   32'd0);
    $display("reset: bcd=%0d busy=%0b done=%0b truth=%02h match=%0b",
             if_a.bcd_out, if_a.busy, if_a.done, if_a.truth, if_a.match);
    @(negedge clk);
    rst = 1'b0;

`ifdef TT_CONTINUOUS_EN
    sel_b = 1'b0;
    done_cnt = 0; busy_ok = 1'b1; prev_truth = 8'h00;
    pulse_start(1'b0);
    for (int e = 1; e <= 55; e++) begin
      @(posedge clk);
      #1;
      if (if_a.busy !== 1'b1) busy_ok = 1'b0;
      if (if_a.done === 1'b1) begin
        if (done_cnt < 3) done_edges[done_cnt] = e;
        done_cnt++;
        chk("cont match", 32'(if_a.match), 32'd1);
        chk("cont truth before done", 32'(prev_truth), 32'hA2);
        $display("continuous sweep %0d: done_at=%0d match=%0b", done_cnt, e, if_a.match);
      end
      prev_truth = if_a.truth;
    end
    chk("cont done count", 32'(done_cnt), 32'd3);
    chk("cont done edge 1", 32'(done_edges[0]), 32'd17);
    chk("cont done edge 2", 32'(done_edges[1]), 32'd34);
    chk("cont done edge 3", 32'(done_edges[2]), 32'd51);
    chk("cont busy held", 32'(busy_ok), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cont rst busy", 32'(if_a.busy), 32'd0);
    chk("cont rst truth", 32'(if_a.truth), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    for (int i = 0; i < 4; i++) sweep(vecs[i]);

    // start re-asserted mid-sweep and during the done cycle is ignored
    sel_b = 1'b0;
    done_cnt = 0;
    pulse_start(1'b0);
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if_a.start = (e == 5 || e == 18);
      @(posedge clk);
      #1;
      if (if_a.done === 1'b1) done_cnt++;
    end
    if_a.start = 1'b0;
    chk("busy-start done count", 32'(done_cnt), 32'd1);
    chk("busy-start idle busy",  32'(if_a.busy), 32'd0);
    chk("idle truth hold",       32'(if_a.truth), 32'hA2);
    chk("idle bcd hold",         32'(if_a.bcd_out), 32'd7);
    chk("idle match hold",       32'(if_a.match), 32'd1);
    $display("busy-start: done pulses=%0d truth=%02h", done_cnt, if_a.truth);
    pulse_start(1'b0);
    chk("restart truth clear", 32'(if_a.truth), 32'd0);
    chk("restart match clear", 32'(if_a.match), 32'd0);
    chk("restart busy",        32'(if_a.busy), 32'd1);
    chk("restart bcd",         32'(if_a.bcd_out), 32'd0);
    $display("restart: truth=%02h busy=%0b", if_a.truth, if_a.busy);
    repeat (20) @(posedge clk);

    // reset at the third SAMPLE cycle discards the partial sweep
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst bcd",   32'(if_a.bcd_out), 32'd0);
    chk("midrst busy",  32'(if_a.busy),    32'd0);
    chk("midrst done",  32'(if_a.done),    32'd0);
    chk("midrst truth", 32'(if_a.truth),   32'd0);
    chk("midrst match", 32'(if_a.match),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (if_a.done === 1'b1 || if_a.busy === 1'b1) done_cnt++;
    end
    chk("midrst no activity", 32'(done_cnt), 32'd0);
    $display("mid-sweep reset: truth=%02h busy=%0b", if_a.truth, if_a.busy);

    // rst together with start in IDLE: reset wins
    sweep(vecs[0]);
    @(negedge clk);
    rst = 1'b1;
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    if_a.start = 1'b0;
    chk("rst+start busy",  32'(if_a.busy),  32'd0);
    chk("rst+start truth", 32'(if_a.truth), 32'd0);
    chk("rst+start match", 32'(if_a.match), 32'd0);
    chk("rst+start bcd",   32'(if_a.bcd_out), 32'd0);
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (if_a.done === 1'b1 || if_a.busy === 1'b1) done_cnt++;
    end
    chk("rst+start no sweep", 32'(done_cnt), 32'd0);
    $display("reset with start: busy=%0b truth=%02h", if_a.busy, if_a.truth);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
